// File: rtl/spi_cmd_controller_pkg.sv
// Shared definitions for the SPI command controller: FSM encoding,
// command word field positions and the response-word builder.
package spi_cmd_controller_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_REQ  = 3'd4;
  localparam logic [2:0] ST_LOAD    = 3'd5;
  localparam logic [2:0] ST_RESP    = 3'd6;

  // Command word layout: {R/nW, address[6:0], data[7:0]}
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;

  // Response word: status bit (1 = access acknowledged) replaces R/nW
  localparam int RESP_STATUS_BIT = 15;

  // Assemble the word shifted back to the master after a read
  function automatic logic [15:0] make_resp(input logic       ok,
                                            input logic [6:0] addr,
                                            input logic [7:0] data);
    logic [15:0] resp;
    resp = '0;
    resp[RESP_STATUS_BIT]   = ok;
    resp[ADDR_MSB:ADDR_LSB] = addr;
    resp[7:0]               = data;
    return resp;
  endfunction

endpackage

// File: rtl/spi_cmd_controller_sync.sv
// Multi-stage synchronizer for a raw SPI pin with registered edge pulses.
// Edges compare the last two synchronized samples, so rise/fall are
// one-cycle pulses aligned one CLK after the synchronized level changes.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rise_reg;
  logic                   fall_reg;

  // Shift the pin through the synchronizer chain and detect edges
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg <= {SYNC_STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
      prev_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
      fall_reg <= ~sync_reg[SYNC_STAGES-1] & prev_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/spi_cmd_controller.sv
// SPI command controller: tracks SPI frames in the CLK domain, decodes
// each 16-bit MOSI word as a register command, runs the req/ack register
// port and preloads the slave's MISO buffer with the read response.
module spi_cmd_controller
  import spi_cmd_controller_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SPI_SCK,
  input  logic              CHIP_SELECT,
  input  logic [WORD_W-1:0] mosi_word,
  output logic [WORD_W-1:0] miso_word,
  output logic              load_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic              frame_err,
  output logic              busy
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  logic              sck_rise, sck_fall, cs_rise, cs_fall;
  logic              cs_active_reg;
  logic              bit_open_reg;
  logic              word_done_reg;
  logic [4:0]        bit_cnt_reg;
  logic [WORD_W-1:0] cmd_reg;
  logic [2:0]        state_reg, state_next;
  logic [TMO_W-1:0]  tmo_reg;
  logic              frame_err_reg, err_next;
  logic [ADDR_W-1:0] reg_addr_reg;
  logic [DATA_W-1:0] reg_wdata_reg;
  logic [WORD_W-1:0] miso_word_reg;
  logic              truncated, frame_open, tmo_expire;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .CLK(CLK), .RST_N(RST_N), .pin(SPI_SCK), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .CLK(CLK), .RST_N(RST_N), .pin(CHIP_SELECT), .rise(cs_rise), .fall(cs_fall)
  );

  // Frame flag and SCK bit accounting; word_done marks the slave's parallel load
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cs_active_reg <= 1'b0;
      bit_open_reg  <= 1'b0;
      bit_cnt_reg   <= '0;
      word_done_reg <= 1'b0;
    end else begin
      word_done_reg <= 1'b0;
      if (cs_fall)      cs_active_reg <= 1'b1;
      else if (cs_rise) cs_active_reg <= 1'b0;
      if (!cs_active_reg) begin
        bit_cnt_reg  <= '0;
        bit_open_reg <= 1'b0;
      end else begin
        // A rising edge without its falling edge is a bit still in flight
        if (sck_rise)      bit_open_reg <= 1'b1;
        else if (sck_fall) bit_open_reg <= 1'b0;
        if (sck_fall) begin
          if (bit_cnt_reg + 5'd1 == 5'(WORD_W)) begin
            bit_cnt_reg   <= '0;
            word_done_reg <= 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
          end
        end
      end
    end
  end

  // Capture the slave's parallel word one CLK after word_done so it has settled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)             cmd_reg <= '0;
    else if (word_done_reg) cmd_reg <= mosi_word;
  end

  assign truncated  = (bit_cnt_reg != 5'd0) || bit_open_reg;
  assign frame_open = cs_active_reg && !cs_rise;
  assign tmo_expire = (tmo_reg == TMO_W'(1));

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state and error-pulse decode
  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE:    if (cs_fall) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (word_done_reg) begin
          state_next = ST_CAPTURE;
        end else if (cs_rise || !cs_active_reg) begin
          state_next = ST_IDLE;
          err_next   = truncated;
        end
      end
      ST_CAPTURE: state_next = cmd_reg[RW_BIT] ? ST_RD_REQ : ST_WR_REQ;
      ST_WR_REQ: begin
        if (reg_ack || tmo_expire) begin
          state_next = frame_open ? ST_SHIFT : ST_IDLE;
          err_next   = !reg_ack;
        end
      end
      ST_RD_REQ: begin
        if (reg_ack || tmo_expire) begin
          state_next = ST_LOAD;
          err_next   = !reg_ack;
        end
      end
      ST_LOAD:    state_next = frame_open ? ST_RESP : ST_IDLE;
      ST_RESP: begin
        if (word_done_reg) begin
          state_next = ST_SHIFT;
        end else if (cs_rise || !cs_active_reg) begin
          state_next = ST_IDLE;
          err_next   = truncated;
        end
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  // Command fields, ack timeout counter, response word and error pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      reg_addr_reg  <= '0;
      reg_wdata_reg <= '0;
      tmo_reg       <= '0;
      miso_word_reg <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= err_next;
      if (state_reg == ST_CAPTURE) begin
        reg_addr_reg  <= cmd_reg[ADDR_MSB:ADDR_LSB];
        reg_wdata_reg <= cmd_reg[DATA_W-1:0];
        tmo_reg       <= TMO_W'(ACK_TIMEOUT);
      end else if (state_reg == ST_WR_REQ || state_reg == ST_RD_REQ) begin
        tmo_reg <= tmo_reg - 1'b1;
      end
      if (state_reg == ST_RD_REQ) begin
        if (reg_ack)         miso_word_reg <= make_resp(1'b1, reg_addr_reg, reg_rdata);
        else if (tmo_expire) miso_word_reg <= make_resp(1'b0, reg_addr_reg, 8'h00);
      end
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    reg_wr    = (state_reg == ST_WR_REQ);
    reg_rd    = (state_reg == ST_RD_REQ);
    load_miso = (state_reg == ST_LOAD);
    busy      = (state_reg != ST_IDLE);
  end

  assign reg_addr  = reg_addr_reg;
  assign reg_wdata = reg_wdata_reg;
  assign miso_word = miso_word_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller: an SPI master task, a slave
// parallel-word model, and a register-bank responder with programmable
// ack latency that also tallies handshakes and output pulses.
module tb_spi_cmd_controller;

  logic        CLK, RST_N, SPI_SCK, CHIP_SELECT;
  logic [15:0] mosi_word, miso_word;
  logic        load_miso, reg_wr, reg_rd, reg_ack, frame_err, busy;
  logic [6:0]  reg_addr;
  logic [7:0]  reg_wdata, reg_rdata;

  int vectors = 0;
  int miscompares = 0;

  // responder / monitor state
  int ack_delay = 1;
  bit ack_en = 1;
  int wait_cnt = 0;
  int load_cnt = 0, err_cnt = 0, rd_cycles = 0, wr_cycles = 0, both_cnt = 0, req_starts = 0;
  bit req_prev = 0;
  logic [15:0] last_loaded = '0;
  logic [6:0] log_addr[$];
  logic [7:0] log_wdata[$];
  int         log_kind[$];   // 1 = write, 2 = read

  spi_cmd_controller dut (
    .CLK(CLK), .RST_N(RST_N), .SPI_SCK(SPI_SCK), .CHIP_SELECT(CHIP_SELECT),
    .mosi_word(mosi_word), .miso_word(miso_word), .load_miso(load_miso),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .frame_err(frame_err), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register bank responder and output pulse monitor
  initial begin
    reg_ack = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      reg_ack = 1'b0;
      if (load_miso) begin load_cnt++; last_loaded = miso_word; end
      if (frame_err) err_cnt++;
      if (reg_rd) rd_cycles++;
      if (reg_wr) wr_cycles++;
      if (reg_wr && reg_rd) both_cnt++;
      if ((reg_wr || reg_rd) && !req_prev) req_starts++;
      req_prev = reg_wr || reg_rd;
      if ((reg_wr || reg_rd) && ack_en) begin
        if (wait_cnt == ack_delay) begin
          reg_ack = 1'b1;
          log_addr.push_back(reg_addr);
          log_wdata.push_back(reg_wdata);
          log_kind.push_back(int'(reg_wr) + 2 * int'(reg_rd));
          $display("[%0t] ack %s addr=%h wdata=%h rdata=%h", $time,
                   reg_wr ? "wr" : "rd", reg_addr, reg_wdata, reg_rdata);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && busy !== 1'b0; n++) begin @(posedge CLK); #2; end
    tick(2);
  endtask

  task automatic cs_low();
    CHIP_SELECT = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40 CHIP_SELECT = 1'b1;
    #40;
  endtask

  // Master clocks nbits (mode 0); the slave loads its parallel word on the 16th fall
  task automatic spi_bits(input logic [15:0] tx, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      #40 SPI_SCK = 1'b1;
      #40 SPI_SCK = 1'b0;
      if (i == 15) mosi_word = tx;
    end
    $display("[%0t] spi word tx=%h bits=%0d", $time, tx, nbits);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CHIP_SELECT = 1'b1; SPI_SCK = 1'b0; mosi_word = '0; reg_rdata = '0;
    tick(3);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (miso_word !== 16'h0) begin miscompares++; $display("FAIL rst_miso got %h want 0000", miso_word); end
    vectors++; if ({reg_wr, reg_rd, load_miso, frame_err} !== 4'b0) begin miscompares++; $display("FAIL rst_pulses got %b want 0000", {reg_wr, reg_rd, load_miso, frame_err}); end
    RST_N = 1'b1;
    tick(10);
    vectors++; if ({busy, reg_addr, reg_wdata} !== 16'h0) begin miscompares++; $display("FAIL rst_idle got %h want 0000", {busy, reg_addr, reg_wdata}); end
  endtask

  task automatic test_write();
    int s_req = req_starts, s_err = err_cnt, s_log = log_addr.size(), s_wr = wr_cycles;
    ack_en = 1; ack_delay = 3;
    cs_low(); spi_bits(16'h1255, 16); cs_high();
    wait_idle();
    vectors++; if (req_starts - s_req !== 1) begin miscompares++; $display("FAIL wr_req_count got %0d want 1", req_starts - s_req); end
    vectors++; if (log_addr.size() - s_log !== 1) begin miscompares++; $display("FAIL wr_ack_count got %0d want 1", log_addr.size() - s_log); end
    vectors++; if (log_addr[s_log] !== 7'h12) begin miscompares++; $display("FAIL wr_addr got %h want 12", log_addr[s_log]); end
    vectors++; if (log_wdata[s_log] !== 8'h55) begin miscompares++; $display("FAIL wr_data got %h want 55", log_wdata[s_log]); end
    vectors++; if (log_kind[s_log] !== 1) begin miscompares++; $display("FAIL wr_kind got %0d want 1", log_kind[s_log]); end
    vectors++; if (wr_cycles - s_wr !== 4) begin miscompares++; $display("FAIL wr_hold_cycles got %0d want 4", wr_cycles - s_wr); end
    vectors++; if (err_cnt - s_err !== 0) begin miscompares++; $display("FAIL wr_frame_err got %0d want 0", err_cnt - s_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy got %b want 0", busy); end
  endtask

  task automatic test_read();
    int s_req = req_starts, s_err = err_cnt, s_log = log_addr.size(), s_ld = load_cnt, s_rd = rd_cycles;
    ack_en = 1; ack_delay = 2; reg_rdata = 8'h3C;
    cs_low(); spi_bits(16'h8A00, 16);
    for (int n = 0; n < 200 && load_cnt == s_ld; n++) begin @(posedge CLK); #2; end
    vectors++; if (load_cnt - s_ld !== 1) begin miscompares++; $display("FAIL rd_load_before_resp got %0d want 1", load_cnt - s_ld); end
    vectors++; if (last_loaded !== 16'h8A3C) begin miscompares++; $display("FAIL rd_loaded_word got %h want 8a3c", last_loaded); end
    vectors++; if (log_kind[s_log] !== 2 || log_addr[s_log] !== 7'h0A) begin miscompares++; $display("FAIL rd_handshake got kind %0d addr %h want 2 0a", log_kind[s_log], log_addr[s_log]); end
    vectors++; if (rd_cycles - s_rd !== 3) begin miscompares++; $display("FAIL rd_hold_cycles got %0d want 3", rd_cycles - s_rd); end
    spi_bits(16'h0000, 16);   // response word, its MOSI content is discarded
    cs_high();
    wait_idle();
    vectors++; if (miso_word !== 16'h8A3C) begin miscompares++; $display("FAIL rd_miso_hold got %h want 8a3c", miso_word); end
    vectors++; if (req_starts - s_req !== 1) begin miscompares++; $display("FAIL rd_req_count got %0d want 1", req_starts - s_req); end
    vectors++; if (load_cnt - s_ld !== 1 || err_cnt - s_err !== 0) begin miscompares++; $display("FAIL rd_pulses got load %0d err %0d want 1 0", load_cnt - s_ld, err_cnt - s_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int s_req = req_starts, s_err = err_cnt, s_log = log_addr.size();
    logic [15:0] w;
    ack_en = 1; ack_delay = 1;
    cs_low();
    for (int k = 1; k <= 3; k++) begin
      w = {k[7:0], k[7:0]};
      spi_bits(w, 16);
      tick(10);
    end
    cs_high();
    wait_idle();
    vectors++; if (log_addr.size() - s_log !== 3) begin miscompares++; $display("FAIL b2b_ack_count got %0d want 3", log_addr.size() - s_log); end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (log_addr[s_log + k] !== 7'(k + 1) || log_wdata[s_log + k] !== 8'(k + 1) || log_kind[s_log + k] !== 1) begin
        miscompares++;
        $display("FAIL b2b_write%0d got addr %h data %h kind %0d want %h %h 1", k, log_addr[s_log + k], log_wdata[s_log + k], log_kind[s_log + k], 7'(k + 1), 8'(k + 1));
      end
    end
    vectors++; if (err_cnt - s_err !== 0 || req_starts - s_req !== 3) begin miscompares++; $display("FAIL b2b_err_req got err %0d req %0d want 0 3", err_cnt - s_err, req_starts - s_req); end
  endtask

  task automatic test_truncation();
    int s_req = req_starts, s_err = err_cnt, s_log;
    ack_en = 1; ack_delay = 1;
    cs_low(); spi_bits(16'hFFFF, 9); cs_high();
    wait_idle();
    vectors++; if (err_cnt - s_err !== 1) begin miscompares++; $display("FAIL trunc_frame_err got %0d want 1", err_cnt - s_err); end
    vectors++; if (req_starts - s_req !== 0) begin miscompares++; $display("FAIL trunc_no_access got %0d want 0", req_starts - s_req); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL trunc_busy got %b want 0", busy); end
    s_log = log_addr.size();
    cs_low(); spi_bits(16'h2A77, 16); cs_high();
    wait_idle();
    vectors++; if (log_addr[s_log] !== 7'h2A || log_wdata[s_log] !== 8'h77 || log_kind[s_log] !== 1) begin miscompares++; $display("FAIL trunc_next_frame got addr %h data %h kind %0d want 2a 77 1", log_addr[s_log], log_wdata[s_log], log_kind[s_log]); end
    vectors++; if (err_cnt - s_err !== 1) begin miscompares++; $display("FAIL trunc_next_err got %0d want 1", err_cnt - s_err); end
  endtask

  task automatic test_timeout();
    int s_err = err_cnt, s_log = log_addr.size(), s_ld = load_cnt, s_rd = rd_cycles;
    ack_en = 0;
    cs_low(); spi_bits(16'h8500, 16);
    for (int n = 0; n < 200 && load_cnt == s_ld; n++) begin @(posedge CLK); #2; end
    vectors++; if (rd_cycles - s_rd !== 15) begin miscompares++; $display("FAIL tmo_rd_cycles got %0d want 15", rd_cycles - s_rd); end
    vectors++; if (err_cnt - s_err !== 1) begin miscompares++; $display("FAIL tmo_frame_err got %0d want 1", err_cnt - s_err); end
    vectors++; if (load_cnt - s_ld !== 1) begin miscompares++; $display("FAIL tmo_load got %0d want 1", load_cnt - s_ld); end
    vectors++; if (last_loaded !== 16'h0500 || miso_word !== 16'h0500) begin miscompares++; $display("FAIL tmo_miso got %h/%h want 0500", last_loaded, miso_word); end
    vectors++; if (reg_rd !== 1'b0 || log_addr.size() != s_log) begin miscompares++; $display("FAIL tmo_rd_dropped got rd %b acks %0d want 0 0", reg_rd, log_addr.size() - s_log); end
    cs_high();
    wait_idle();
    vectors++; if (busy !== 1'b0 || err_cnt - s_err !== 1) begin miscompares++; $display("FAIL tmo_end got busy %b err %0d want 0 1", busy, err_cnt - s_err); end
    ack_en = 1;
  endtask

  task automatic test_reset_mid_frame();
    int s_req, s_err, s_log;
    ack_en = 1; ack_delay = 1;
    cs_low(); spi_bits(16'h3344, 7);
    #40 SPI_SCK = 1'b1;
    #20 RST_N = 1'b0;
    #1;
    vectors++; if ({reg_wr, reg_rd, load_miso, frame_err, busy} !== 5'b0) begin miscompares++; $display("FAIL rstmid_ctrl got %b want 00000", {reg_wr, reg_rd, load_miso, frame_err, busy}); end
    vectors++; if ({miso_word, reg_addr, reg_wdata} !== 31'h0) begin miscompares++; $display("FAIL rstmid_data got %h %h %h want 0", miso_word, reg_addr, reg_wdata); end
    #19 SPI_SCK = 1'b0;
    tick(5);
    RST_N = 1'b1;
    s_req = req_starts; s_err = err_cnt;
    tick(20);
    cs_high();
    wait_idle();
    vectors++; if (req_starts - s_req !== 0 || err_cnt - s_err !== 0) begin miscompares++; $display("FAIL rstmid_no_access got req %0d err %0d want 0 0", req_starts - s_req, err_cnt - s_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy); end
    s_log = log_addr.size();
    cs_low(); spi_bits(16'h0B0C, 16); cs_high();
    wait_idle();
    vectors++; if (log_addr[s_log] !== 7'h0B || log_wdata[s_log] !== 8'h0C || req_starts - s_req !== 1) begin miscompares++; $display("FAIL rstmid_fresh_frame got addr %h data %h req %0d want 0b 0c 1", log_addr[s_log], log_wdata[s_log], req_starts - s_req); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_truncation();
    test_timeout();
    test_reset_mid_frame();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL wr_rd_exclusive got %0d overlap cycles want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
